// File: rtl/speed_tick_gen.sv
// Game-speed tick generator: one registered Tick pulse per movement step at one of
// LEVELS speeds (each level halves the period), selected manually or ramped automatically.
module speed_tick_gen #(
    parameter int unsigned BASE_DIV   = 25000000,
    parameter int unsigned LEVELS     = 4,
    parameter int unsigned RAMP_TICKS = 16,
    parameter int unsigned CW         = 26,
    parameter int unsigned LW         = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable,
    input  logic [LW-1:0] Level,
    input  logic          RampEn,
    output logic          Tick,
    output logic [LW-1:0] CurLevel,
    output logic [15:0]   TickCount
);

    localparam int unsigned   RW        = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int unsigned   TW        = 16;
    localparam logic [LW-1:0] MAX_LVL   = LW'(LEVELS - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
    localparam logic [31:0]   BASE      = 32'(BASE_DIV);

    logic [CW-1:0] count_q,      count_d;
    logic [RW-1:0] ramp_cnt_q,   ramp_cnt_d;
    logic          tick_q,       tick_d;
    logic [LW-1:0] level_q,      level_d;
    logic [TW-1:0] tick_count_q, tick_count_d;

    logic [CW-1:0] last_c;
    logic [LW-1:0] target_c;

    // Terminal count of the current period and the clamped manual level request
    assign last_c   = CW'((BASE >> level_q) - 32'd1);
    assign target_c = (Level > MAX_LVL) ? MAX_LVL : Level;

    always_comb begin
        count_d      = count_q;
        ramp_cnt_d   = ramp_cnt_q;
        tick_d       = 1'b0;
        level_d      = level_q;
        tick_count_d = tick_count_q;

        if (Enable) begin
            if (!RampEn && (target_c != level_q)) begin
                // Level switch restarts the period; a tick due on this edge is dropped
                level_d    = target_c;
                count_d    = '0;
                ramp_cnt_d = '0;
            end else if (count_q == last_c) begin
                count_d      = '0;
                tick_d       = 1'b1;
                tick_count_d = tick_count_q + TW'(1);
                if (RampEn) begin
                    if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_d = '0;
                        if (level_q < MAX_LVL) begin
                            level_d = level_q + LW'(1);
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RW'(1);
                    end
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q      <= '0;
            ramp_cnt_q   <= '0;
            tick_q       <= 1'b0;
            level_q      <= '0;
            tick_count_q <= '0;
        end else begin
            count_q      <= count_d;
            ramp_cnt_q   <= ramp_cnt_d;
            tick_q       <= tick_d;
            level_q      <= level_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign Tick      = tick_q;
    assign CurLevel  = level_q;
    assign TickCount = tick_count_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Scoreboard bench for speed_tick_gen: expected ticks (edge, count, level) are queued
// by the stimulus and popped by a negedge monitor whenever Tick is high.
module tb_speed_tick_gen;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [1:0]  Level;
    logic        RampEn;
    logic        Tick;
    logic [1:0]  CurLevel;
    logic [15:0] TickCount;

    speed_tick_gen #(
        .BASE_DIV  (16),
        .LEVELS    (4),
        .RAMP_TICKS(3),
        .CW        (5),
        .LW        (2)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .Level    (Level),
        .RampEn   (RampEn),
        .Tick     (Tick),
        .CurLevel (CurLevel),
        .TickCount(TickCount)
    );

    typedef struct {
        int edge_no;
        int cnt;
        int lvl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   base  = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int e, input int c, input int l);
        exp_t x;
        x.edge_no = base + e;
        x.cnt     = c;
        x.lvl     = l;
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input logic [1:0] lv, input logic ramp);
        Reset  = 1'b1;
        Level  = lv;
        RampEn = ramp;
        Enable = 1'b1;
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        base  = edge_n;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    task automatic wait_q_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clock);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every Tick pulse must match the next queued expectation
    always @(negedge Clock) begin
        if (!Reset && Tick) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", int'(Tick), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tick_edge",  edge_n,         e.edge_no);
                check("tick_count", int'(TickCount), e.cnt);
                check("tick_level", int'(CurLevel),  e.lvl);
            end
        end
    end

    initial begin
        int r_edge [15] = '{16, 32, 48, 56, 64, 72, 76, 80, 84, 86, 88, 90, 92, 94, 111};
        int r_lvl  [15] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};

        Reset  = 1'b1;
        Enable = 1'b0;
        Level  = 2'd0;
        RampEn = 1'b0;
        #12;
        check("rst_tick",  int'(Tick),      0);
        check("rst_level", int'(CurLevel),  0);
        check("rst_count", int'(TickCount), 0);

        // Basic period at level 0
        do_reset(2'd0, 1'b0);
        push(16, 1, 0);
        push(32, 2, 0);
        push(48, 3, 0);
        wait_q_empty(80);
        check("basic_level", int'(CurLevel),  0);
        check("basic_count", int'(TickCount), 3);

        // Level 2 held from reset: switch on edge 1, then period 4
        do_reset(2'd2, 1'b0);
        push(5, 1, 2);
        push(9, 2, 2);
        push(13, 3, 2);
        wait_edges(1);
        check("lvl2_cur", int'(CurLevel), 2);
        wait_q_empty(40);

        // Level 3: period 2
        do_reset(2'd3, 1'b0);
        push(3, 1, 3);
        push(5, 2, 3);
        push(7, 3, 3);
        wait_q_empty(40);

        // Mid-period change 0 -> 1 at count 10
        do_reset(2'd0, 1'b0);
        push(19, 1, 1);
        push(27, 2, 1);
        wait_edges(10);
        Level = 2'd1;
        wait_edges(1);
        check("mid_cur", int'(CurLevel), 1);
        wait_q_empty(40);

        // Ramp through all levels, saturate, then drop back to manual level 0
        do_reset(2'd0, 1'b1);
        for (int i = 0; i < 15; i++) push(r_edge[i], i + 1, r_lvl[i]);
        wait_edges(94);
        RampEn = 1'b0;
        wait_edges(1);
        check("ramp_drop_level", int'(CurLevel), 0);
        wait_q_empty(40);

        // Pause 5 cycles at count 7: tick stretches from 16 to 21 cycles
        do_reset(2'd0, 1'b0);
        push(16, 1, 0);
        push(37, 2, 0);
        wait_edges(23);
        Enable = 1'b0;
        wait_edges(3);
        check("pause_count", int'(TickCount), 1);
        wait_edges(2);
        Enable = 1'b1;
        wait_q_empty(40);

        // Async reset between edges while Tick is high at level 2
        do_reset(2'd2, 1'b0);
        push(5, 1, 2);
        wait_edges(5);
        check("async_pre_tick",  int'(Tick),     1);
        check("async_pre_level", int'(CurLevel), 2);
        #2;
        Reset = 1'b1;
        #1;
        check("async_tick",  int'(Tick),      0);
        check("async_level", int'(CurLevel),  0);
        check("async_count", int'(TickCount), 0);
        check("async_queue", exp_q.size(),    0);
        exp_q.delete();

        // TickCount wrap 65535 -> 0
        do_reset(2'd3, 1'b0);
        push(3, 0, 3);
        push(5, 1, 3);
        wait_edges(2);
        force dut.tick_count_q = 16'hFFFF;
        #1;
        release dut.tick_count_q;
        wait_q_empty(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speed_tick_gen.md
# speed_tick_gen

Parametrised game-speed tick generator for the car game. It produces one single-cycle `Tick` pulse per movement step at one of `LEVELS` speeds, where each level halves the period of the previous one. Speed is selected by a binary level input, or advanced automatically in ramp mode, so difficulty rises over time. It sits between the system clock and the object-movement/draw FSMs, which advance one step per `Tick`.

## Interface
Parameters:
- `BASE_DIV`, default 25000000: tick period at level 0, in clock cycles (0.5 s at 50 MHz).
- `LEVELS`, default 4: number of speed levels; level L period = `BASE_DIV >> L`.
- `RAMP_TICKS`, default 16: ticks emitted at one level before ramp mode advances to the next level.
- `CW`, default 26: period counter width; must hold `BASE_DIV-1`.
- `LW`, default 2: level width; must satisfy `2**LW >= LEVELS`.

Legality requirement: `BASE_DIV >> (LEVELS-1) >= 2`.

Ports:
- `Clock` in 1: system clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Enable` in 1: run; low freezes all state.
- `Level` in LW: requested speed level (manual mode).
- `RampEn` in 1: 1 = automatic ramp mode, 0 = manual mode.
- `Tick` out 1: registered one-cycle step pulse.
- `CurLevel` out LW: level currently in force.
- `TickCount` out 16: total ticks emitted since reset.

## Operation
- Internal state:
  - `count` (CW bits).
  - `ramp_cnt`, wide enough for `RAMP_TICKS-1`.
  - Registered outputs `Tick`, `CurLevel`, `TickCount`.
- Period: `P = BASE_DIV >> CurLevel`.
- Target level in manual mode: `min(Level, LEVELS-1)`; out-of-range requests clamp.
- Per clock edge, apply the first matching rule in this priority order:
  1. `Reset` high (asynchronous): `count`=0, `ramp_cnt`=0, `Tick`=0, `CurLevel`=0, `TickCount`=0.
  2. `Enable`=0: all state holds, except `Tick`<=0.
  3. Manual mode (`RampEn`=0) and target level != `CurLevel`: `CurLevel`<=target, `count`<=0, `ramp_cnt`<=0, `Tick`<=0. A tick due on this edge is dropped.
  4. `count == P-1`: `count`<=0, `Tick`<=1, `TickCount`<=`TickCount`+1 (wraps 65535->0). In ramp mode, additionally:
     - If `ramp_cnt == RAMP_TICKS-1`: `ramp_cnt`<=0, and `CurLevel` increments if below `LEVELS-1`, otherwise holds.
     - Else `ramp_cnt` increments.
  5. Otherwise: `count`<=`count`+1, `Tick`<=0.
- Ramp mode ignores `Level`. When `RampEn` falls, rule 3 applies on the next edge if `Level` differs from the ramped `CurLevel`.
- Entering ramp mode does not reset `CurLevel`; ramping starts from the current level.
- Once `CurLevel` is at `LEVELS-1`, ramp mode keeps ticking at that period indefinitely.

## Timing
- Reset values: `Tick`=0, `CurLevel`=0, `TickCount`=0.
- Tick spacing: exactly P cycles between rising edges of `Tick`. `Tick` is high for exactly one cycle.
- Startup: after `Reset` release with `Enable`=1, the first `Tick` is high after the P-th rising edge.
- Level change (manual): the new period applies immediately. The first tick at the new level is high after the P_new-th edge following the change edge.
- Ramp step: the level increments on the same edge as the `RAMP_TICKS`-th tick at that level. The next tick follows after P_new cycles.
- `Enable` low for N cycles stretches the current period by exactly N cycles. A pending tick is never lost, only delayed.
- `Reset` asserted mid-period clears outputs immediately, without waiting for a clock edge.

## Test plan
Bench parameters: `BASE_DIV`=16, `LEVELS`=4, `RAMP_TICKS`=3, `LW`=2.

- **Basic period:** Reset, then `Enable`=1, `Level`=0, `RampEn`=0 -> `Tick` high after edges 16, 32, 48; `TickCount`=3; `CurLevel`=0.
- **Level periods:** `Level`=2 held from reset -> `CurLevel`=2 after first edge; ticks every 4 cycles. `Level`=3 -> ticks every 2 cycles.
- **Mid-period level change:** `Level` 0->1 when `count`=10 -> no tick on the change edge; next `Tick` 8 edges later, then every 8.
- **Ramp:** `RampEn`=1 from reset -> 3 ticks spaced 16, then 3 spaced 8, then 3 spaced 4, then spacing 2 forever. `CurLevel` steps 0,1,2,3 and saturates at 3. Dropping `RampEn` with `Level`=0 -> `CurLevel`=0 next edge.
- **Pause:** `Enable` low for 5 cycles at `count`=7 (level 0) -> that tick arrives 21 cycles after the previous one; `TickCount` unchanged during the pause.
- **Async reset:** `Reset` pulsed between clock edges while `Tick`=1 and `CurLevel`=2 -> `Tick`=0, `CurLevel`=0, `TickCount`=0 before the next edge. Separately, force `TickCount` to 65535 and emit one tick -> `TickCount`=0.
